mode_finder_stream: RTL and testbench

Streaming successor to the team's fixed 8×2-bit combinational majority finder. It accepts symbols one per cycle over a valid/ready handshake and accumulates a per-value histogram over a window of NUM symbols. It then scans the histogram sequentially and presents the most frequent value and its count on a valid/ready result port. It sits between a symbol producer (decoder/demapper) and downstream voting or statistics logic.

---
 rtl/mode_finder_stream_if.sv | 33 +++
 rtl/mode_finder_stream.sv | 97 +++++++++
 tb/tb_mode_finder_stream.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mode_finder_stream_if.sv
// rtl/mode_finder_stream_if.sv - symbol-in / result-out handshake bundle for mode_finder_stream (MODE_FINDER_FLUSH_EN adds in_last)
interface mode_finder_stream_if #(
    parameter int DW = 2,
    parameter int NUM = 8,
    localparam int CW = $clog2(NUM + 1)
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
`ifdef MODE_FINDER_FLUSH_EN
    logic          in_last;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] max_data;
    logic [CW-1:0] max_cnt;

    modport master (
`ifdef MODE_FINDER_FLUSH_EN
        output in_last,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, max_data, max_cnt
    );

    modport slave (
`ifdef MODE_FINDER_FLUSH_EN
        input  in_last,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, max_data, max_cnt
    );
endinterface

// File: rtl/mode_finder_stream.sv
// rtl/mode_finder_stream.sv - windowed histogram mode finder with sequential scan (MODE_FINDER_FLUSH_EN enables early window end)
module mode_finder_stream #(
    parameter int DW = 2,
    parameter int NUM = 8,
    localparam int CW = $clog2(NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    mode_finder_stream_if.slave  bus,
    output logic                 busy
);
    localparam int NB = 1 << DW;

    typedef enum logic [1:0] {ACC, SCAN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bin [NB];
    logic [CW-1:0] sym_cnt;
    logic [DW-1:0] idx;
    logic [DW-1:0] best_val;
    logic [CW-1:0] best_cnt;
    logic          accept;
    logic          win_end;

    assign accept = (state == ACC) && bus.in_valid;

`ifdef MODE_FINDER_FLUSH_EN
    assign win_end = (sym_cnt == CW'(NUM - 1)) || bus.in_last;
`else
    assign win_end = (sym_cnt == CW'(NUM - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            for (int i = 0; i < NB; i++) bin[i] <= '0;
            sym_cnt  <= '0;
            idx      <= '0;
            best_val <= '0;
            best_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ACC: begin
                    if (accept) begin
                        bin[bus.in_data] <= bin[bus.in_data] + CW'(1);
                        sym_cnt          <= sym_cnt + CW'(1);
                        if (win_end) begin
                            idx      <= '0;
                            best_val <= '0;
                            best_cnt <= '0;
                        end
                    end
                end
                SCAN: begin
                    // strict compare keeps the lowest value on ties
                    if (bin[idx] > best_cnt) begin
                        best_cnt <= bin[idx];
                        best_val <= idx;
                    end
                    idx <= idx + DW'(1);
                end
                DONE: begin
                    if (bus.out_ready) begin
                        for (int i = 0; i < NB; i++) bin[i] <= '0;
                        sym_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && win_end) state_nxt = SCAN;
            end
            SCAN: begin
                if (idx == {DW{1'b1}}) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACC;
            end
            default: state_nxt = ACC;
        endcase
    end

    assign bus.max_data = best_val;
    assign bus.max_cnt  = best_cnt;
    assign busy         = (state != ACC) || (sym_cnt != '0);
endmodule

// File: tb/tb_mode_finder_stream.sv
// tb/tb_mode_finder_stream.sv - scoreboard bench for mode_finder_stream
module tb_mode_finder_stream;
    localparam int DW = 2;
    localparam int NUM = 8;
    localparam int CW = $clog2(NUM + 1);
    localparam int NB = 1 << DW;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    mode_finder_stream_if #(.DW(DW), .NUM(NUM)) bus ();

    mode_finder_stream #(.DW(DW), .NUM(NUM)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int syms[8], input int n, input bit last);
        int   hist[NB];
        exp_t e;
        for (int v = 0; v < NB; v++) hist[v] = 0;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = syms[i][DW-1:0];
`ifdef MODE_FINDER_FLUSH_EN
            bus.in_last  = last && (i == n - 1);
`endif
            hist[syms[i]]++;
            step();
        end
        bus.in_valid = 1'b0;
`ifdef MODE_FINDER_FLUSH_EN
        bus.in_last  = 1'b0;
`endif
        e.d = '0;
        e.c = '0;
        for (int v = 0; v < NB; v++) begin
            if (hist[v] > int'(e.c)) begin
                e.c = CW'(hist[v]);
                e.d = DW'(v);
            end
        end
        sb.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 40) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, n, NB);
    endtask

    task automatic take(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, "_out_valid"}, int'(bus.out_valid), 1);
        check_eq({tag, "_max_data"}, int'(bus.max_data), int'(e.d));
        check_eq({tag, "_max_cnt"}, int'(bus.max_cnt), int'(e.c));
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, int'(bus.out_valid), 0);
        check_eq({tag, "_in_ready_back"}, int'(bus.in_ready), 1);
        check_eq({tag, "_busy_clear"}, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef MODE_FINDER_FLUSH_EN
        bus.in_last   = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_max_data", int'(bus.max_data), 0);
        check_eq("rst_max_cnt", int'(bus.max_cnt), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_in_ready", int'(bus.in_ready), 1);

        send('{0, 1, 1, 2, 3, 1, 0, 1}, 8, 1'b0);
        wait_result("basic");
        check_eq("basic_plan_data", int'(bus.max_data), 1);
        check_eq("basic_plan_cnt", int'(bus.max_cnt), 4);
        take("basic");

        send('{3, 3, 2, 2, 1, 1, 0, 0}, 8, 1'b0);
        wait_result("tie_a");
        take("tie_a");
        send('{3, 3, 3, 2, 2, 2, 1, 0}, 8, 1'b0);
        wait_result("tie_b");
        check_eq("tie_b_plan_data", int'(bus.max_data), 2);
        take("tie_b");

        send('{3, 3, 3, 3, 3, 3, 3, 3}, 8, 1'b0);
        wait_result("full");
        check_eq("full_plan_cnt", int'(bus.max_cnt), 8);
        take("full");

        send('{3, 3, 3, 2, 2, 2, 1, 0}, 8, 1'b0);
        wait_result("bp");
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 2'd2;
            step();
            check_eq("bp_in_ready", int'(bus.in_ready), 0);
            check_eq("bp_hold_valid", int'(bus.out_valid), 1);
            check_eq("bp_hold_data", int'(bus.max_data), 2);
            check_eq("bp_hold_cnt", int'(bus.max_cnt), 3);
        end
        bus.in_valid = 1'b0;
        take("bp");
        send('{0, 0, 0, 0, 0, 0, 0, 0}, 8, 1'b0);
        wait_result("bp_next");
        check_eq("bp_next_plan_cnt", int'(bus.max_cnt), 8);
        take("bp_next");

        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 2'd3;
            step();
        end
        bus.in_valid = 1'b0;
        check_eq("mid_busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_busy_after", int'(busy), 0);
        check_eq("mid_in_ready", int'(bus.in_ready), 1);
        check_eq("mid_out_valid", int'(bus.out_valid), 0);
        send('{1, 1, 1, 1, 2, 2, 2, 0}, 8, 1'b0);
        wait_result("mid");
        check_eq("mid_plan_data", int'(bus.max_data), 1);
        take("mid");

`ifdef MODE_FINDER_FLUSH_EN
        send('{2, 2, 1, 0, 0, 0, 0, 0}, 3, 1'b1);
        wait_result("flush");
        check_eq("flush_plan_cnt", int'(bus.max_cnt), 2);
        take("flush");
`endif

        check_eq("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
